// File: rtl/alu_4bit_arb.sv
// alu_4bit_arb: round-robin arbiter sharing one combinational alu_4bit
// between two requesters, with a single-entry registered response slot.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           requester N handshake (ready is the grant)
//   reqN_x, reqN_y, reqN_sel   requester N operands and opcode
//   rsp_valid/ready            response slot handshake
//   rsp_out, rsp_cout,
//   rsp_zero, rsp_id           registered ALU result and issuing requester
//   op_cnt0, op_cnt1           accepted-response counters (wrap)
//
// alu_4bit (same file): combinational 4-bit ALU.
//   ADD: Cout = carry out. SUB: Cout = borrow (X < Y). Logic ops: Cout = 0.
//   Zero = (ALU_Out == 0).

module alu_4bit (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [2:0] Sel,
  output logic [3:0] ALU_Out,
  output logic       Cout,
  output logic       Zero
);
  logic [4:0] res;

  always_comb begin
    res = 5'd0;
    case (Sel)
      3'b000:  res = {1'b0, X} + {1'b0, Y};
      3'b001:  res = {1'b0, X} - {1'b0, Y};  // bit 4 set on borrow
      3'b010:  res = {1'b0, X & Y};
      3'b011:  res = {1'b0, X | Y};
      3'b100:  res = {1'b0, X ^ Y};
      3'b101:  res = {1'b0, ~(X & Y)};
      3'b110:  res = {1'b0, ~(X | Y)};
      default: res = {1'b0, ~(X ^ Y)};
    endcase
  end

  assign ALU_Out = res[3:0];
  assign Cout    = res[4];
  assign Zero    = (res[3:0] == 4'd0);
endmodule

module alu_4bit_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_x,
  input  logic [3:0]       req0_y,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_x,
  input  logic [3:0]       req1_y,
  input  logic [2:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_out,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_cnt0,
  output logic [CNT_W-1:0] op_cnt1
);
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] sel;
  } req_t;

  typedef struct packed {
    logic [3:0] out;
    logic       cout;
    logic       zero;
    logic       id;
  } rsp_t;

  typedef enum logic {EMPTY, FULL} slot_e;

  req_t [1:0] req;
  logic [1:0] vld, gnt;
  req_t       alu_in;
  logic [3:0] alu_out;
  logic       alu_cout, alu_zero;
  slot_e      state, state_nxt;
  rsp_t       rsp_q;
  logic       last_id;
  logic       slot_free, any_gnt, rsp_accept;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  assign req[0] = {req0_x, req0_y, req0_sel};
  assign req[1] = {req1_x, req1_y, req1_sel};
  assign vld    = {req1_valid, req0_valid};

  assign rsp_valid  = (state == FULL);
  assign slot_free  = !rsp_valid || rsp_ready;
  assign rsp_accept = rsp_valid && rsp_ready;

  // Grant is gated by rst_n so no requester sees ready while in reset.
  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (rst_n && slot_free) begin
      if (&vld) gnt = last_id ? 2'b01 : 2'b10;
      else      gnt = vld;
    end
  end

  assign any_gnt    = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Idle cycles steer requester 0 into the ALU; the result is not loaded.
  assign alu_in = gnt[1] ? req[1] : req[0];

  alu_4bit u_alu (
    .X       (alu_in.x),
    .Y       (alu_in.y),
    .Sel     (alu_in.sel),
    .ALU_Out (alu_out),
    .Cout    (alu_cout),
    .Zero    (alu_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (any_gnt) state_nxt = FULL;
      FULL:    if (rsp_ready && !any_gnt) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rsp_q   <= '0;
      last_id <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        rsp_q   <= '{out: alu_out, cout: alu_cout, zero: alu_zero, id: gnt[1]};
        last_id <= gnt[1];
      end
      // Counts the response leaving the slot, so it uses the old rsp_id
      // even when the slot reloads on the same edge.
      if (rsp_accept) begin
        if (rsp_q.id) cnt1_q <= cnt1_q + 1'b1;
        else          cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign rsp_out  = rsp_q.out;
  assign rsp_cout = rsp_q.cout;
  assign rsp_zero = rsp_q.zero;
  assign rsp_id   = rsp_q.id;
  assign op_cnt0  = cnt0_q;
  assign op_cnt1  = cnt1_q;
endmodule

// File: tb/tb_alu_4bit_arb.sv
module tb_alu_4bit_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_x, req0_y, req1_x, req1_y;
  logic [2:0] req0_sel, req1_sel;
  logic       rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_id;
  logic [3:0] rsp_out;
  logic [7:0] op_cnt0, op_cnt1;

  always #5 clk = ~clk;

  alu_4bit_arb #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one-deep response slot plus round-robin memory.
  bit m_valid;
  int m_out, m_cout, m_zero, m_id, m_last;
  int m_cnt[2];
  bit e_g0, e_g1;  // expected grants of the most recent cycle

  // Values sampled at the negedge of the most recent cycle
  int s_r0, s_r1, s_v, s_out, s_cout, s_zero, s_id, s_c0, s_c1;

  function automatic void alu_ref(input int x, input int y, input int sel,
                                  output int o, output int c, output int z);
    int r;
    case (sel)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 15 - (x & y);
      6: r = 15 - (x | y);
      default: r = 15 - (x ^ y);
    endcase
    c = ((sel < 2) && (r < 0 || r > 15)) ? 1 : 0;
    o = (r + 16) % 16;
    z = (o == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_out = 0; m_cout = 0; m_zero = 0; m_id = 0;
    m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // One clock: drive inputs, check at negedge, update model at posedge.
  task automatic cycle(input bit v0, input int x0, input int y0, input int s0,
                       input bit v1, input int x1, input int y1, input int s1,
                       input bit rr, input string tag);
    bit free;
    int o, c, z;
    req0_valid = v0; req0_x = 4'(x0); req0_y = 4'(y0); req0_sel = 3'(s0);
    req1_valid = v1; req1_x = 4'(x1); req1_y = 4'(y1); req1_sel = 3'(s1);
    rsp_ready  = rr;
    free = !m_valid || rr;
    e_g0 = 0; e_g1 = 0;
    if (free) begin
      if (v0 && v1) begin
        if (m_last == 1) e_g0 = 1; else e_g1 = 1;
      end else begin
        e_g0 = v0; e_g1 = v1;
      end
    end
    @(negedge clk);
    s_r0 = int'(req0_ready); s_r1 = int'(req1_ready); s_v = int'(rsp_valid);
    s_out = int'(rsp_out); s_cout = int'(rsp_cout); s_zero = int'(rsp_zero);
    s_id = int'(rsp_id); s_c0 = int'(op_cnt0); s_c1 = int'(op_cnt1);
    chk({tag, ":ready0"}, s_r0, int'(e_g0));
    chk({tag, ":ready1"}, s_r1, int'(e_g1));
    chk({tag, ":one_ready"}, int'(req0_ready && req1_ready), 0);
    chk({tag, ":rsp_valid"}, s_v, int'(m_valid));
    if (m_valid) begin
      chk({tag, ":rsp_out"}, s_out, m_out);
      chk({tag, ":rsp_cout"}, s_cout, m_cout);
      chk({tag, ":rsp_zero"}, s_zero, m_zero);
      chk({tag, ":rsp_id"}, s_id, m_id);
    end
    chk({tag, ":op_cnt0"}, s_c0, m_cnt[0]);
    chk({tag, ":op_cnt1"}, s_c1, m_cnt[1]);
    @(posedge clk);
    if (m_valid && rr) m_cnt[m_id] = (m_cnt[m_id] + 1) % 256;
    if (e_g0 || e_g1) begin
      if (e_g1) alu_ref(x1, y1, s1, o, c, z);
      else      alu_ref(x0, y0, s0, o, c, z);
      m_valid = 1; m_out = o; m_cout = c; m_zero = z;
      m_id = e_g1 ? 1 : 0; m_last = m_id;
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic idle(input bit rr, input string tag);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, rr, tag);
  endtask

  typedef struct {
    int x, y, sel, out, cout, zero;
  } vec_t;

  vec_t tv[$];

  bit pv[2];
  int px[2], py[2], ps[2];
  int base0, base1;

  initial begin
    // Directed ALU vectors, issued from requester 1
    tv.push_back('{x: 3,  y: 1, sel: 2, out: 1,  cout: 0, zero: 0});
    tv.push_back('{x: 3,  y: 1, sel: 3, out: 3,  cout: 0, zero: 0});
    tv.push_back('{x: 3,  y: 1, sel: 4, out: 2,  cout: 0, zero: 0});
    tv.push_back('{x: 3,  y: 1, sel: 5, out: 14, cout: 0, zero: 0});
    tv.push_back('{x: 3,  y: 1, sel: 6, out: 12, cout: 0, zero: 0});
    tv.push_back('{x: 3,  y: 1, sel: 7, out: 13, cout: 0, zero: 0});
    tv.push_back('{x: 3,  y: 1, sel: 1, out: 2,  cout: 0, zero: 0});
    tv.push_back('{x: 1,  y: 3, sel: 1, out: 14, cout: 1, zero: 0});
    tv.push_back('{x: 5,  y: 5, sel: 1, out: 0,  cout: 0, zero: 1});
    tv.push_back('{x: 9,  y: 8, sel: 0, out: 1,  cout: 1, zero: 0});
    tv.push_back('{x: 12, y: 3, sel: 2, out: 0,  cout: 0, zero: 1});

    // Reset state, with both requesters valid
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 4'd1; req0_y = 4'd1; req0_sel = 3'd0;
    req1_x = 4'd2; req1_y = 4'd2; req1_sel = 3'd0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst:ready0", int'(req0_ready), 0);
    chk("rst:ready1", int'(req1_ready), 0);
    chk("rst:rsp_valid", int'(rsp_valid), 0);
    chk("rst:rsp_out", int'(rsp_out), 0);
    chk("rst:rsp_flags", int'({rsp_cout, rsp_zero, rsp_id}), 0);
    chk("rst:op_cnt0", int'(op_cnt0), 0);
    chk("rst:op_cnt1", int'(op_cnt1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request after reset
    cycle(1, 3, 1, 0, 0, 0, 0, 0, 1, "single");
    chk("single:granted", s_r0, 1);
    idle(1, "single_rsp");
    chk("single:valid", s_v, 1);
    chk("single:out", s_out, 4);
    chk("single:id", s_id, 0);
    chk("single:zero", s_zero, 0);
    idle(1, "single_cnt");
    chk("single:cnt0", s_c0, 1);

    // ADD wrap-around from requester 1
    cycle(0, 0, 0, 0, 1, 15, 1, 0, 1, "wrap_add");
    idle(1, "wrap_add_rsp");
    chk("wrap_add:out", s_out, 0);
    chk("wrap_add:cout", s_cout, 1);
    chk("wrap_add:zero", s_zero, 1);
    chk("wrap_add:id", s_id, 1);

    // Table of ALU vectors
    foreach (tv[i]) begin
      cycle(0, 0, 0, 0, 1, tv[i].x, tv[i].y, tv[i].sel, 1, "vec");
      idle(1, "vec_rsp");
      chk($sformatf("vec%0d:out", i), s_out, tv[i].out);
      chk($sformatf("vec%0d:cout", i), s_cout, tv[i].cout);
      chk($sformatf("vec%0d:zero", i), s_zero, tv[i].zero);
    end

    // Contention: last winner was requester 1, so 0,1,0,1
    base0 = m_cnt[0]; base1 = m_cnt[1];
    for (int i = 0; i < 4; i++) begin
      cycle(1, i, 2, 0, 1, i, 3, 1, 1, "cont");
      chk($sformatf("cont%0d:grant1", i), s_r1, i % 2);
      if (i > 0) chk($sformatf("cont%0d:rsp_id", i), s_id, (i - 1) % 2);
    end
    idle(1, "cont_tail");
    chk("cont:last_id", s_id, 1);
    idle(1, "cont_cnt");
    chk("cont:cnt0", s_c0, (base0 + 2) % 256);
    chk("cont:cnt1", s_c1, (base1 + 2) % 256);

    // Backpressure: slot FULL with 5+6=11 and rsp_ready low
    cycle(1, 5, 6, 0, 0, 0, 0, 0, 1, "bp_load");
    for (int i = 0; i < 3; i++) begin
      cycle(1, 7, 7, 1, 0, 0, 0, 0, 0, "bp_hold");
      chk("bp_hold:ready0", s_r0, 0);
      chk("bp_hold:out", s_out, 11);
      chk("bp_hold:valid", s_v, 1);
    end
    base0 = m_cnt[0];
    cycle(1, 7, 7, 1, 0, 0, 0, 0, 1, "bp_release");
    chk("bp_release:ready0", s_r0, 1);
    idle(1, "bp_after");
    chk("bp_after:out", s_out, 0);
    chk("bp_after:zero", s_zero, 1);
    chk("bp_after:cnt0", s_c0, (base0 + 1) % 256);

    // Randomized traffic; operands held until granted
    pv[0] = 0; pv[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 2) != 0) begin
          pv[r] = 1;
          px[r] = int'($urandom_range(0, 15));
          py[r] = int'($urandom_range(0, 15));
          ps[r] = int'($urandom_range(0, 7));
        end
      end
      cycle(pv[0], px[0], py[0], ps[0], pv[1], px[1], py[1], ps[1],
            $urandom_range(0, 3) != 0, "rand");
      if (e_g0) pv[0] = 0;
      if (e_g1) pv[1] = 0;
    end

    // Counter wrap: fresh reset, then 256 accepted req0 ops
    rst_n = 1'b0; model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++)
      cycle(1, i % 16, 1, 0, 0, 0, 0, 0, 1, "cnt_wrap");
    chk("cnt_wrap:cnt0", int'(op_cnt0), 0);
    chk("cnt_wrap:full", int'(rsp_valid), 1);

    // Reset while FULL
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst:valid", int'(rsp_valid), 0);
    chk("midrst:cnt0", int'(op_cnt0), 0);
    chk("midrst:cnt1", int'(op_cnt1), 0);
    chk("midrst:out", int'(rsp_out), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 2, 2, 0, 1, 3, 3, 0, 1, "post_rst");
    chk("post_rst:grant0", s_r0, 1);
    idle(1, "post_rst_rsp");
    chk("post_rst:out", s_out, 4);
    idle(1, "post_rst_cnt");
    chk("post_rst:cnt0", s_c0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_4bit_arb.md
# alu_4bit_arb

Two-port round-robin arbiter that shares one `alu_4bit` instance between two independent requesters. Each requester presents an operand pair and opcode with a valid/ready handshake. The arbiter grants one request per cycle, registers the ALU result into a single-entry response slot tagged with the requester ID, and holds it until the consumer accepts it. It sits between the issuing blocks and the combinational ALU and is the only driver of the ALU inputs.

## Interface

**Parameters**
- `CNT_W`, default 8: width of the per-requester completed-operation counters.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req0_valid`, in, 1: requester 0 has an operation pending.
- `req0_ready`, out, 1: requester 0 is granted this cycle.
- `req0_x`, in, 4: requester 0 operand X.
- `req0_y`, in, 4: requester 0 operand Y.
- `req0_sel`, in, 3: requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_y`, `req1_sel`: same as requester 0, for requester 1.
- `rsp_valid`, out, 1: the response slot holds a result.
- `rsp_ready`, in, 1: the consumer accepts the result this cycle.
- `rsp_out`, out, 4: registered `ALU_Out`.
- `rsp_cout`, out, 1: registered `Cout`.
- `rsp_zero`, out, 1: registered `Zero`.
- `rsp_id`, out, 1: requester that issued the held result.
- `op_cnt0`, out, `CNT_W`: number of results accepted from requester 0.
- `op_cnt1`, out, `CNT_W`: number of results accepted from requester 1.

## Operation

- **Opcodes** are passed straight to `alu_4bit`:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR, 111 XNOR.
  - `Cout` and `Zero` are captured unmodified; the arbiter never alters them.
- **Slot free**: `slot_free = !rsp_valid || rsp_ready`.
- **Grant** is combinational from `req0_valid`, `req1_valid`, `last_id` and `slot_free`:
  - If `slot_free` is 0, there is no grant and both readys are 0.
  - If exactly one requester is valid, it is granted.
  - If both are valid, grant the requester other than `last_id`.
- **Ready signals**:
  - `reqN_ready` = granted to N.
  - At most one ready is high in any cycle.
  - Ready depends on valid; requesters must not make valid depend on ready.
- **ALU input mux**:
  - The ALU inputs follow the granted requester.
  - When nothing is granted, they are driven from requester 0 and the result is ignored.
- **Handshake rules**:
  - A request completes when `reqN_valid && reqN_ready`.
  - A response completes when `rsp_valid && rsp_ready`.
  - Requesters hold operands stable while valid and not ready.
- **Slot states** (2):
  - EMPTY (`rsp_valid`=0): a grant loads the slot and moves to FULL.
  - FULL (`rsp_valid`=1):
    - `rsp_ready`=1 with a new grant: reload the slot in the same edge and stay FULL. Back-to-back throughput is one op per cycle.
    - `rsp_ready`=1 with no grant: go to EMPTY.
    - `rsp_ready`=0: hold all `rsp_*` unchanged.
- **`last_id`** updates to the granted ID on every grant.
- **Counters**:
  - `op_cntN` increments when a response with `rsp_id`=N is accepted.
  - They wrap modulo 2^`CNT_W` (255 → 0 at the default width).

## Timing

- **Reset** (async assert, synchronous release on `clk`):
  - `rsp_valid`=0; `rsp_out`=0; `rsp_cout`=0; `rsp_zero`=0; `rsp_id`=0; `op_cnt0`=0; `op_cnt1`=0.
  - `last_id`=1, so requester 0 wins the first contended cycle.
- **Readys are combinational**; during reset both readys are 0.
- **Latency**:
  - A request accepted at edge N produces `rsp_valid`=1 with its result after edge N.
  - That response can be accepted at edge N+1.
- **Simultaneous events**:
  - Response accept and new grant in one cycle: the counter for the old `rsp_id` increments and the slot reloads with the new result.
  - Both requesters valid every cycle with `rsp_ready`=1: grants alternate 0,1,0,1,…
- **Reset mid-operation**: a held or in-flight result is discarded and not counted. After release, behaviour is identical to power-up.

## Test plan

- **Single request after reset**: req0 X=3, Y=1, sel=000, `rsp_ready`=1.
  - `req0_ready`=1 in that cycle.
  - Next cycle: `rsp_out`=4, `rsp_id`=0, `rsp_zero`=0.
  - One cycle later: `op_cnt0`=1.
- **ADD wrap-around**: req1 X=F, Y=1, sel=000.
  - `rsp_out`=0, `rsp_cout`=1, `rsp_zero`=1, `rsp_id`=1.
- **Contention**: both requesters valid for 4 cycles with `rsp_ready`=1.
  - Grants and `rsp_id` sequence 0,1,0,1.
  - `op_cnt0`=`op_cnt1`=2.
  - Never both readys high.
- **Backpressure**: slot FULL, `rsp_ready`=0 for 3 cycles, req0 valid.
  - `req0_ready`=0 throughout.
  - `rsp_*` unchanged.
  - Raise `rsp_ready`: old result accepted and req0 granted in the same cycle.
- **Logic ops**: X=3, Y=1 through sel 010..111.
  - `rsp_out` = 1, 3, 2, E, C, D respectively.
- **Counter wrap and reset**: 256 accepted req0 ops gives `op_cnt0`=0. Then assert `rst_n`=0 while FULL:
  - `rsp_valid`=0 immediately.
  - Counters cleared.
  - After release, the first contended grant goes to requester 0.
